// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Brief    : Shared widths, FSM encoding and Q1.15 arithmetic constants for
//            the time-multiplexed FIR engine.
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int c_data_w  = 16;
  localparam int c_prod_w  = 32;
  localparam int c_frac    = 15;
  localparam int c_round   = 1 << 14;
  localparam int c_sat_max = 32767;
  localparam int c_sat_min = -32768;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_mac  = 2'd1;
  localparam logic [1:0] c_st_out  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = c_st_idle,
    ST_MAC  = c_st_mac,
    ST_OUT  = c_st_out
  } fir_state_e;

endpackage
`default_nettype wire

// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
// Module   : multiplier
// Brief    : Combinational 16x16 signed multiplier with full 32-bit product.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [31:0] p
);

  assign p = a * b;

endmodule
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer
// Brief    : Q1.15 FIR lowpass; one shared multiplier walks all taps per sample,
//            then a rounded, saturated result is presented until consumed.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int  TAPS  = 16,
  parameter int  ACC_W = 40,
  localparam int IDX_W = $clog2(TAPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [c_data_w-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [c_data_w-1:0] out_data,
  input  logic                       coef_we,
  input  logic [IDX_W-1:0]           coef_addr,
  input  logic signed [c_data_w-1:0] coef_data,
  output logic                       busy
);

  localparam logic signed [ACC_W-1:0] c_rnd_ext = ACC_W'(c_round);
  localparam logic signed [ACC_W-1:0] c_max_ext = ACC_W'(c_sat_max);
  localparam logic signed [ACC_W-1:0] c_min_ext = ACC_W'(c_sat_min);

  logic [1:0]                 r_state;
  logic [IDX_W-1:0]           r_idx;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [c_data_w-1:0] r_out;
  logic signed [c_data_w-1:0] r_x [TAPS];
  logic signed [c_data_w-1:0] r_c [TAPS];

  logic signed [c_prod_w-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [ACC_W-1:0]    w_rnd;
  logic signed [ACC_W-1:0]    w_shr;
  logic signed [c_data_w-1:0] w_sat;
  logic                       w_idle;
  logic                       w_last;
  logic                       w_addr_ok;

  assign w_idle    = (r_state == c_st_idle);
  assign in_ready  = w_idle;
  assign out_valid = (r_state == c_st_out);
  assign busy      = !w_idle;
  assign out_data  = r_out;
  assign w_last    = (r_idx == IDX_W'(TAPS - 1));

  // Only non-power-of-two banks have addresses that fall outside the array.
  generate
    if (TAPS == (1 << IDX_W)) begin : g_addr_pow2
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_npow2
      assign w_addr_ok = (coef_addr < IDX_W'(TAPS));
    end
  endgenerate

  multiplier u_mult (
    .a (r_x[r_idx]),
    .b (r_c[r_idx]),
    .p (w_prod)
  );

  // The final accumulate and the output rounding share one edge, so the
  // result is formed from the running sum plus the last product.
  assign w_prod_ext = {{(ACC_W - c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;
  assign w_rnd      = w_sum + c_rnd_ext;
  assign w_shr      = w_rnd >>> c_frac;

  always_comb begin
    w_sat = w_shr[c_data_w-1:0];
    if (w_shr > c_max_ext) begin
      w_sat = c_data_w'(c_sat_max);
    end else if (w_shr < c_min_ext) begin
      w_sat = c_data_w'(c_sat_min);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_idx   <= '0;
      r_acc   <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= c_st_mac;
          end
        end
        c_st_mac: begin
          r_acc <= w_sum;
          if (w_last) begin
            r_out   <= w_sat;
            r_state <= c_st_out;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        c_st_out: begin
          if (out_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Coefficient writes are honoured only while idle; anything else is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
        r_c[k] <= '0;
      end
    end else begin
      if (w_idle && in_valid) begin
        r_x[0] <= in_data;
        for (int k = 1; k < TAPS; k++) begin
          r_x[k] <= r_x[k-1];
        end
      end
      if (w_idle && coef_we && w_addr_ok) begin
        r_c[coef_addr] <= coef_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_sequencer
// Brief    : Scoreboard bench; an arithmetic FIR model queues expected outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

  localparam int TAPS  = 16;
  localparam int ACC_W = 40;
  localparam int AW    = $clog2(TAPS);

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               coef_we;
  logic [AW-1:0]      coef_addr;
  logic signed [15:0] coef_data;
  logic               busy;

  fir_mac_sequencer #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;
  bit     rand_bp = 1'b0;
  longint mx [TAPS];
  longint mc [TAPS];
  longint exp_q [$];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every output handshake is checked against the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", longint'(out_data), -99999);
      end else begin
        check("out_data", longint'(out_data), exp_q.pop_front());
      end
    end
  end

  // Reference FIR: y = sat16(round(sum x[n-k]*c[k] / 2^15)).
  function automatic void model_clear();
    for (int k = 0; k < TAPS; k++) begin
      mx[k] = 0;
      mc[k] = 0;
    end
  endfunction

  function automatic void model_accept(input longint x);
    longint s = 0;
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = x;
    for (int k = 0; k < TAPS; k++) s += mx[k] * mc[k];
    s = (s + 16384) >>> 15;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    exp_q.push_back(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input int data, input bit applies);
    logic signed [15:0] d16;
    d16       = 16'(data);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = d16;
    if (applies) mc[addr] = longint'(d16);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic send(input int x, output int acc_cyc);
    int n = 0;
    logic signed [15:0] x16;
    x16      = 16'(x);
    in_valid = 1'b1;
    in_data  = x16;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    acc_cyc = cyc;
    if (!in_ready) begin
      check("accept_timeout", n, 0);
    end else begin
      model_accept(longint'(x16));
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("drain_timeout", n, 0);
  endtask

  initial begin
    int c_acc;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_clear();
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);

    // Impulse response reproduces the coefficients, then returns to zero.
    for (int k = 0; k < TAPS; k++) write_coef(k, 1000 * (k + 1), 1'b1);
    send(32767, c_acc);
    for (int k = 0; k < TAPS; k++) send(0, c_acc);
    drain();

    // Latency from acceptance cycle to first out_valid cycle.
    send(1234, c_acc);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("latency", cyc - c_acc, TAPS + 1);
    drain();

    // DC saturation in both directions.
    for (int k = 0; k < TAPS; k++) write_coef(k, 8192, 1'b1);
    for (int i = 0; i < 20; i++) send(32767, c_acc);
    for (int i = 0; i < 20; i++) send(-32768, c_acc);
    drain();

    // Back-pressure with the next sample held on in_valid.
    out_ready = 1'b0;
    send(12000, c_acc);
    in_valid = 1'b1;
    in_data  = 16'sd7000;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      if (exp_q.size() != 0) check("bp_out_data_stable", out_data, exp_q[0]);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_ready_after_handshake", in_ready, 1);
    model_accept(7000);
    tick();
    in_valid = 1'b0;
    check("bp_held_sample_accepted", busy, 1);
    drain();

    // Coefficient write while busy is dropped; the same write in idle lands.
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 40000)) - 20000, 1'b1);
    write_coef(0, -5000, 1'b1);
    send(20000, c_acc);
    repeat (3) tick();
    write_coef(0, 16384, 1'b0);
    drain();
    coef_we = 1'b1; coef_addr = '0; coef_data = 16'sd16384;
    mc[0] = 16384;
    send(15000, c_acc);
    coef_we = 1'b0;
    drain();

    // Random coefficients and samples under random back-pressure.
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 65535)), 1'b1);
    rand_bp = 1'b1;
    for (int i = 0; i < 30; i++) send(int'($urandom_range(0, 65535)), c_acc);
    rand_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset in the middle of the MAC sweep.
    send(9999, c_acc);
    repeat (7) tick();
    #2;
    rst = 1'b1;
    #1;
    check("amid_out_valid", out_valid, 0);
    check("amid_out_data", out_data, 0);
    check("amid_busy", busy, 0);
    check("amid_in_ready", in_ready, 1);
    exp_q.delete();
    model_clear();
    tick();
    tick();
    rst = 1'b0;
    tick();
    send(32767, c_acc);
    for (int k = 0; k < TAPS; k++) send(0, c_acc);
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
